// File: rtl/vw_bulk_fifo.sv
// Virtual-wire bulk byte buffer: captures 256-bit host frames on A/B strobes,
// unpacks payload bytes into a byte FIFO drained through a two-register Wishbone slave.
module vw_bulk_fifo #(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic [15:0]  wb_dat_i,
    output logic [15:0]  wb_dat_o,
    input  logic         wb_we_i,
    input  logic         wb_adr_i,
    input  logic [1:0]   wb_sel_i,
    input  logic         wb_stb_i,
    input  logic         wb_cyc_i,
    output logic         wb_ack_o,
    input  logic [255:0] vw_bulkdata_in,
    output logic [31:0]  vw_status_out,
    output logic         fifo_nonempty_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_UNPACK = 1'b1
    } state_t;

    logic                  r_sa1, r_sa2, r_sb1, r_sb2;
    state_t                r_state, w_state_nxt;
    logic [247:0]          r_shift;
    logic [4:0]            r_cnt;
    logic [15:0]           r_frame_cnt;
    logic                  r_ovr;
    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic                  r_ack;
    logic [15:0]           r_dat_o;
    logic [31:0]           r_status;
    logic                  r_nonempty;

    logic       w_op, w_act, w_rd_data, w_rd_stat, w_flush, w_ovr_clr;
    logic       w_event, w_pop, w_push, w_push_ok, w_capture, w_ovr_set;
    logic [7:0] w_head;
    logic [10:0] w_level_ext;
    logic       w_unused;

    assign w_unused   = ^{wb_sel_i, vw_bulkdata_in[253], wb_dat_i[14:1]};

    assign w_op       = wb_stb_i & wb_cyc_i;
    assign w_act      = w_op & ~r_ack;
    assign w_rd_data  = w_act & ~wb_we_i & ~wb_adr_i;
    assign w_rd_stat  = w_act & ~wb_we_i &  wb_adr_i;
    assign w_flush    = w_act &  wb_we_i & ~wb_adr_i & wb_dat_i[0];
    assign w_ovr_clr  = w_act &  wb_we_i &  wb_adr_i & wb_dat_i[15];
    assign w_event    = (r_sa1 & ~r_sa2) | (r_sb1 & ~r_sb2);
    assign w_pop      = w_rd_data & (r_level != {LW{1'b0}});
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign w_push_ok  = (r_level < LVL_FULL) | w_pop;
    assign w_push     = (r_state == ST_UNPACK) & w_push_ok & ~w_flush;
    assign w_head     = w_pop ? r_mem[r_rd_ptr] : 8'h00;
    assign w_level_ext = 11'(r_level);

    // Two-flop synchronisers for the host strobes.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_sa1 <= 1'b0;
            r_sa2 <= 1'b0;
            r_sb1 <= 1'b0;
            r_sb2 <= 1'b0;
        end else begin
            r_sa1 <= vw_bulkdata_in[255];
            r_sa2 <= r_sa1;
            r_sb1 <= vw_bulkdata_in[254];
            r_sb2 <= r_sb1;
        end
    end

    // Unpacker next state, capture and overrun decisions; flush overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_ovr_set   = 1'b0;
        if (w_flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_event) begin
                        w_capture   = 1'b1;
                        w_state_nxt = (vw_bulkdata_in[252:248] == 5'd0) ? ST_IDLE : ST_UNPACK;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_UNPACK: begin
                    w_ovr_set = w_event;
                    if (w_push && (r_cnt == 5'd1)) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_UNPACK;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Unpacker state register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame shift register, remaining byte count and frame counter.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_shift     <= 248'd0;
            r_cnt       <= 5'd0;
            r_frame_cnt <= 16'd0;
        end else if (w_capture) begin
            r_shift     <= vw_bulkdata_in[247:0];
            r_cnt       <= vw_bulkdata_in[252:248];
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end else if (w_push) begin
            r_shift     <= {8'h00, r_shift[247:8]};
            r_cnt       <= r_cnt - 5'd1;
        end
    end

    // Sticky overrun; a same-cycle set beats the clear.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ovr <= 1'b0;
        end else if (w_ovr_set) begin
            r_ovr <= 1'b1;
        end else if (w_ovr_clr) begin
            r_ovr <= 1'b0;
        end
    end

    // FIFO storage.
    always_ff @(posedge wb_clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_shift[7:0];
        end
    end

    // FIFO pointers and level.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // Wishbone acknowledge and read data.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ack   <= 1'b0;
            r_dat_o <= 16'h0000;
        end else begin
            r_ack <= r_ack ? 1'b0 : w_op;
            if (w_rd_data) begin
                r_dat_o <= {w_pop, r_ovr, 6'b000000, w_head};
            end else if (w_rd_stat) begin
                r_dat_o <= {r_ovr, (r_state == ST_UNPACK), 3'b000, w_level_ext};
            end
        end
    end

    // Host status word and interrupt-style non-empty flag.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_status   <= 32'h0000_0000;
            r_nonempty <= 1'b0;
        end else begin
            r_status   <= {r_frame_cnt, (r_state == ST_UNPACK), r_ovr, 3'b000, w_level_ext};
            r_nonempty <= (r_level != {LW{1'b0}});
        end
    end

    assign wb_dat_o        = r_dat_o;
    assign wb_ack_o        = r_ack;
    assign vw_status_out   = r_status;
    assign fifo_nonempty_o = r_nonempty;

endmodule

// File: tb/tb_vw_bulk_fifo.sv
// Directed bench for vw_bulk_fifo: a vector table for the basic frame/read flow,
// then hand sequences for fill/stall, overrun, flush and asynchronous reset.
module tb_vw_bulk_fifo;

    logic         clk;
    logic         rst;
    logic [15:0]  wb_dat_i;
    logic [15:0]  wb_dat_o;
    logic         wb_we_i;
    logic         wb_adr_i;
    logic [1:0]   wb_sel_i;
    logic         wb_stb_i;
    logic         wb_cyc_i;
    logic         wb_ack_o;
    logic [255:0] vec;
    logic [31:0]  status;
    logic         nonempty;

    int checks = 0;
    int errors = 0;

    vw_bulk_fifo #(.DEPTH_LOG2(6)) dut (
        .wb_clk_i        (clk),
        .wb_rst_i        (rst),
        .wb_dat_i        (wb_dat_i),
        .wb_dat_o        (wb_dat_o),
        .wb_we_i         (wb_we_i),
        .wb_adr_i        (wb_adr_i),
        .wb_sel_i        (wb_sel_i),
        .wb_stb_i        (wb_stb_i),
        .wb_cyc_i        (wb_cyc_i),
        .wb_ack_o        (wb_ack_o),
        .vw_bulkdata_in  (vec),
        .vw_status_out   (status),
        .fifo_nonempty_o (nonempty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;    // 0 read, 1 write, 2 frame on A, 3 frame on A+B
        logic        adr;
        logic [15:0] wd;
        logic [4:0]  cnt;
        logic [23:0] pl;
        logic [31:0] exp;   // read data, or status word after a frame
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic wb_op(input logic we, input logic adr, input logic [15:0] wd,
                         output logic [15:0] rd);
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = wd;
        wb_stb_i = 1'b1;
        wb_cyc_i = 1'b1;
        @(posedge clk); #1;
        chk("ack", {31'd0, wb_ack_o}, 32'd1);
        rd       = wb_dat_o;
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        wb_we_i  = 1'b0;
        wb_dat_i = 16'h0000;
        @(posedge clk); #1;
        chk("ack_pulse", {31'd0, wb_ack_o}, 32'd0);
    endtask

    task automatic send_frame(input logic a, input logic b, input logic [4:0] cnt,
                              input logic [247:0] pl, input int cyc);
        vec = {a, b, 1'b0, cnt, pl};
        repeat (cyc) @(posedge clk);
        #1;
        vec[255] = 1'b0;
        vec[254] = 1'b0;
    endtask

    logic [15:0]  rd;
    logic [247:0] big;

    initial begin
        tbl[0]  = '{2'd0, 1'b1, 16'h0000, 5'd0, 24'h000000, 32'h0000_0000};
        tbl[1]  = '{2'd0, 1'b0, 16'h0000, 5'd0, 24'h000000, 32'h0000_0000};
        tbl[2]  = '{2'd2, 1'b0, 16'h0000, 5'd3, 24'h332211, 32'h0001_0003};
        tbl[3]  = '{2'd0, 1'b0, 16'h0000, 5'd0, 24'h000000, 32'h0000_8011};
        tbl[4]  = '{2'd0, 1'b0, 16'h0000, 5'd0, 24'h000000, 32'h0000_8022};
        tbl[5]  = '{2'd0, 1'b1, 16'h0000, 5'd0, 24'h000000, 32'h0000_0001};
        tbl[6]  = '{2'd0, 1'b0, 16'h0000, 5'd0, 24'h000000, 32'h0000_8033};
        tbl[7]  = '{2'd0, 1'b0, 16'h0000, 5'd0, 24'h000000, 32'h0000_0000};
        tbl[8]  = '{2'd3, 1'b0, 16'h0000, 5'd2, 24'h00BBAA, 32'h0002_0002};
        tbl[9]  = '{2'd0, 1'b0, 16'h0000, 5'd0, 24'h000000, 32'h0000_80AA};
        tbl[10] = '{2'd0, 1'b0, 16'h0000, 5'd0, 24'h000000, 32'h0000_80BB};
        tbl[11] = '{2'd2, 1'b0, 16'h0000, 5'd0, 24'hDDCCBB, 32'h0003_0000};
        tbl[12] = '{2'd0, 1'b1, 16'h0000, 5'd0, 24'h000000, 32'h0000_0000};

        rst = 1'b1; vec = '0; wb_dat_i = 16'h0000; wb_we_i = 1'b0; wb_adr_i = 1'b0;
        wb_sel_i = 2'b11; wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_dat", {16'd0, wb_dat_o}, 32'd0);
        chk("rst_ack", {31'd0, wb_ack_o}, 32'd0);
        chk("rst_status", status, 32'd0);
        chk("rst_nonempty", {31'd0, nonempty}, 32'd0);

        for (int i = 0; i < 13; i++) begin
            case (tbl[i].op)
                2'd0: begin
                    wb_op(1'b0, tbl[i].adr, 16'h0000, rd);
                    chk($sformatf("tbl%0d_rd", i), {16'd0, rd}, tbl[i].exp);
                end
                2'd1: wb_op(1'b1, tbl[i].adr, tbl[i].wd, rd);
                default: begin
                    send_frame(1'b1, tbl[i].op[0], tbl[i].cnt, {224'd0, tbl[i].pl}, 10);
                    chk($sformatf("tbl%0d_status", i), status, tbl[i].exp);
                    chk($sformatf("tbl%0d_nonempty", i), {31'd0, nonempty},
                        {31'd0, (tbl[i].exp[10:0] != 11'd0)});
                end
            endcase
        end

        // Fill: three 31-byte frames into a 64-byte FIFO.
        for (int k = 0; k < 31; k++) big[8*k +: 8] = 8'(k + 1);
        send_frame(1'b1, 1'b0, 5'd31, big, 40);
        chk("fill1_status", status, 32'h0004_001F);
        send_frame(1'b0, 1'b1, 5'd31, big, 40);
        chk("fill2_status", status, 32'h0005_003E);
        send_frame(1'b1, 1'b0, 5'd31, big, 40);
        chk("fill3_status", status, 32'h0006_8040);
        wb_op(1'b0, 1'b1, 16'h0000, rd);
        chk("full_stat", {16'd0, rd}, 32'h0000_4040);
        wb_op(1'b0, 1'b0, 16'h0000, rd);
        chk("full_pop", {16'd0, rd}, 32'h0000_8001);
        wb_op(1'b0, 1'b1, 16'h0000, rd);
        chk("full_refill", {16'd0, rd}, 32'h0000_4040);

        // Overrun while stalled, then clear it.
        send_frame(1'b1, 1'b0, 5'd5, big, 6);
        wb_op(1'b0, 1'b1, 16'h0000, rd);
        chk("ovr_stat", {16'd0, rd}, 32'h0000_C040);
        chk("ovr_status", status, 32'h0006_C040);
        wb_op(1'b1, 1'b1, 16'h8000, rd);
        wb_op(1'b0, 1'b1, 16'h0000, rd);
        chk("ovr_clr", {16'd0, rd}, 32'h0000_4040);

        // Flush mid-unpack.
        wb_op(1'b1, 1'b0, 16'h0001, rd);
        wb_op(1'b0, 1'b1, 16'h0000, rd);
        chk("flush_stat", {16'd0, rd}, 32'h0000_0000);
        chk("flush_status", status, 32'h0006_0000);
        chk("flush_nonempty", {31'd0, nonempty}, 32'd0);

        // Asynchronous reset mid-unpack.
        send_frame(1'b1, 1'b0, 5'd31, big, 6);
        chk("pre_rst_busy", {31'd0, status[15]}, 32'd1);
        wb_op(1'b0, 1'b1, 16'h0000, rd);
        chk("pre_rst_rd_busy", {31'd0, rd[14]}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_dat", {16'd0, wb_dat_o}, 32'd0);
        chk("arst_ack", {31'd0, wb_ack_o}, 32'd0);
        chk("arst_status", status, 32'd0);
        chk("arst_nonempty", {31'd0, nonempty}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        wb_op(1'b0, 1'b1, 16'h0000, rd);
        chk("post_rst_stat", {16'd0, rd}, 32'h0000_0000);
        chk("post_rst_status", status, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
